fpga_runner: RTL
================

FPGA_RUNNER -- requirements
Module: fpga_runner

Interface
REQ-001 Parameter WIDTH, default 16: data register width in bits.
REQ-002 Parameter REGS, default 8: register count, power of two, RB = log2(REGS).
REQ-003 Parameter DEPTH, default 64: program memory depth, power of two, AB = log2(DEPTH).
REQ-004 Parameter MAX_STEPS, default 1024: watchdog limit in executed instructions.
REQ-005 Instruction word IW = 4+3*RB+WIDTH bits, fields MSB..LSB: op[4], dst[RB], a[RB], b[RB], imm[WIDTH].
REQ-006 clock  input  1  sole clock, all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 prog_we  input  1  program memory write strobe.
REQ-009 prog_addr  input  AB  program memory write address.
REQ-010 prog_data  input  IW  program memory write data.
REQ-011 start  input  1  begin execution at ip 0.
REQ-012 finished  output  1  high once the program has stopped, held until next start or reset.
REQ-013 success  output  1  valid while finished; high only if no failure occurred.
REQ-014 ip  output  AB  current instruction pointer.
REQ-015 fail_ip  output  AB  ip of first failing instruction, 0 if none.

Function
REQ-016 States IDLE, RUN, DONE; IDLE->RUN and DONE->RUN on start; RUN->DONE on HALT, failure stop, run-off or watchdog.
REQ-017 prog_we writes prog_data to prog_addr in IDLE and DONE; ignored in RUN.
REQ-018 On start: ip=0, all registers 0, fail flag 0, fail_ip 0, step count 0, finished=0, success=0; first instruction executes the next cycle.
REQ-019 RUN executes exactly one instruction per cycle, memory read combinational on ip.
REQ-020 op 0 NOP: ip+1.
REQ-021 op 1 MOVI: R[dst]=imm; ip+1.
REQ-022 op 2 ADD: R[dst]=(R[a]+R[b]) mod 2^WIDTH; op 3 SUB: R[dst]=(R[a]-R[b]) mod 2^WIDTH; ip+1.
REQ-023 op 4 ASSERTEQ: if R[a]!=R[b] set fail flag, record fail_ip if first failure; execution continues; ip+1.
REQ-024 op 5 JNZ: if R[a]!=0 ip=imm[AB-1:0], else ip+1.
REQ-025 op 6 HALT: go DONE, finished=1, success=!fail flag.
REQ-026 ops 7-15 illegal: set fail flag, record fail_ip, go DONE with success=0.
REQ-027 Non-jump instruction at ip=DEPTH-1 (run-off): fail, go DONE, success=0; ip does not wrap.
REQ-028 start asserted during RUN is ignored.
REQ-029 finished and success change only on the RUN->DONE edge, in the same cycle.

Reset
REQ-030 reset low asynchronously forces IDLE, finished=0, success=0, ip=0, fail_ip=0, registers 0; program memory contents are not cleared.
REQ-031 reset low mid-RUN aborts execution; finished stays 0 until a new start completes.

Configuration
REQ-032 Macro FPGA_RUNNER_WATCHDOG_EN defined: step count reaching MAX_STEPS in RUN forces DONE, success=0, fail_ip=ip at abort.
REQ-033 Macro FPGA_RUNNER_WATCHDOG_EN undefined: no step counter; RUN continues until HALT, illegal op or run-off.

Verification
REQ-034 Load MOVI R1=3, MOVI R2=4, ADD R3=R1+R2, MOVI R4=7, ASSERTEQ R3,R4, HALT; start -> finished=1, success=1 after 6 RUN cycles.
REQ-035 Same program with MOVI R4=8 -> finished=1, success=0, fail_ip=4.
REQ-036 WIDTH=16: MOVI R1=0xFFFF, MOVI R2=1, ADD R3, MOVI R4=0, ASSERTEQ R3,R4, HALT -> success=1 (wrap to 0).
REQ-037 Loop MOVI R1=5, MOVI R2=1, SUB R1=R1-R2, JNZ R1->2, HALT -> success=1, 13 RUN cycles to finished.
REQ-038 Program JNZ R1(=0 after MOVI R1=1 loop back forever) with watchdog enabled, MAX_STEPS=1024 -> finished=1, success=0 after 1024 steps; disabled -> finished stays 0.
REQ-039 reset low at cycle 3 of RUN -> finished=0, ip=0 immediately; prog_we during RUN leaves memory unchanged; op 9 -> success=0.

Source files
------------

// File: rtl/fpga_runner.sv
// fpga_runner: a small test-program sequencer. A program is loaded into an
// internal memory, then executed one instruction per clock against a bank of
// general registers. ASSERTEQ instructions record failures, and the run ends
// with a finished/success verdict.
//
// Optional build macro: FPGA_RUNNER_WATCHDOG_EN adds a step-count watchdog
// that aborts a run after MAX_STEPS executed instructions.
//
// Ports:
//   clock      sole clock, all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   prog_we    program memory write strobe (ignored while running)
//   prog_addr  program memory write address
//   prog_data  program memory write data {op, dst, a, b, imm}
//   start      begin execution at ip 0 (ignored while running)
//   finished   high once the program has stopped
//   success    valid while finished; high only if no failure occurred
//   ip         current instruction pointer
//   fail_ip    ip of the first failing instruction, 0 if none
module fpga_runner #(
  parameter int WIDTH     = 16,
  parameter int REGS      = 8,
  parameter int DEPTH     = 64,
  parameter int MAX_STEPS = 1024,
  localparam int RB = $clog2(REGS),
  localparam int AB = $clog2(DEPTH),
  localparam int IW = 4 + 3*RB + WIDTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AB-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          start,
  output logic          finished,
  output logic          success,
  output logic [AB-1:0] ip,
  output logic [AB-1:0] fail_ip
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOVI = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AEQ  = 4'd4;
  localparam logic [3:0] OP_JNZ  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd6;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [IW-1:0]    mem [DEPTH];
  logic [WIDTH-1:0] regs [REGS];
  logic             fail_flag;

  logic [IW-1:0]    instr;
  logic [3:0]       op;
  logic [RB-1:0]    dst, fa, fb;
  logic [WIDTH-1:0] imm, ra, rb;
  logic             at_end, jump_taken;

  logic             stop, fail_now, reg_we;
  logic [WIDTH-1:0] reg_wdata;
  logic [AB-1:0]    ip_nxt;

`ifdef FPGA_RUNNER_WATCHDOG_EN
  localparam int SW = $clog2(MAX_STEPS + 1);
  logic [SW-1:0] steps;
`else
  // MAX_STEPS only matters when the watchdog is built in.
  if (MAX_STEPS < 1) begin : g_steps_unused
  end
`endif

  // Modulo-2^WIDTH arithmetic: the natural vector width wraps the result.
  function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    return x + y;
  endfunction

  function automatic logic [WIDTH-1:0] wrap_sub(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    return x - y;
  endfunction

  // Program memory is not reset: contents survive reset and restarts.
  always_ff @(posedge clock) begin
    if (prog_we && state != S_RUN) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Decode: combinational fetch from the current ip.
  always_comb begin
    instr      = mem[ip];
    op         = instr[IW-1 -: 4];
    dst        = instr[IW-5 -: RB];
    fa         = instr[IW-5-RB -: RB];
    fb         = instr[IW-5-2*RB -: RB];
    imm        = instr[WIDTH-1:0];
    ra         = regs[fa];
    rb         = regs[fb];
    at_end     = (ip == AB'(DEPTH - 1));
    jump_taken = (op == OP_JNZ) && (ra != '0);
  end

  // Execute: one instruction's effects and whether the run stops here.
  always_comb begin
    stop      = 1'b0;
    fail_now  = 1'b0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    ip_nxt    = ip + AB'(1);
    case (op)
      OP_NOP:  ;
      OP_MOVI: begin reg_we = 1'b1; reg_wdata = imm;              end
      OP_ADD:  begin reg_we = 1'b1; reg_wdata = wrap_add(ra, rb); end
      OP_SUB:  begin reg_we = 1'b1; reg_wdata = wrap_sub(ra, rb); end
      OP_AEQ:  fail_now = (ra != rb);
      OP_JNZ:  if (jump_taken) ip_nxt = imm[AB-1:0];
      OP_HALT: stop = 1'b1;
      default: begin stop = 1'b1; fail_now = 1'b1; end
    endcase
    // Falling off the last address is a failure; ip never wraps.
    if (!stop && at_end && !jump_taken) begin
      stop     = 1'b1;
      fail_now = 1'b1;
    end
`ifdef FPGA_RUNNER_WATCHDOG_EN
    // The MAX_STEPS-th executed instruction is the last one allowed.
    if (!stop && steps == SW'(MAX_STEPS - 1)) begin
      stop     = 1'b1;
      fail_now = 1'b1;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (stop)  state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    finished = (state == S_DONE);
    success  = (state == S_DONE) && !fail_flag;
  end

  // Architectural state: cleared by reset and by every accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ip        <= '0;
      fail_ip   <= '0;
      fail_flag <= 1'b0;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
`ifdef FPGA_RUNNER_WATCHDOG_EN
      steps     <= '0;
`endif
    end else if (state != S_RUN && start) begin
      ip        <= '0;
      fail_ip   <= '0;
      fail_flag <= 1'b0;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
`ifdef FPGA_RUNNER_WATCHDOG_EN
      steps     <= '0;
`endif
    end else if (state == S_RUN) begin
      if (reg_we) regs[dst] <= reg_wdata;
      if (fail_now && !fail_flag) fail_ip <= ip;
      if (fail_now) fail_flag <= 1'b1;
      // On the stopping instruction ip stays put, pointing at it.
      if (!stop) ip <= ip_nxt;
`ifdef FPGA_RUNNER_WATCHDOG_EN
      steps     <= steps + SW'(1);
`endif
    end
  end

endmodule
